// File: rtl/srl_fifo_rd32x36_if.sv
// Producer/consumer bundle for the shift-register FIFO.
// The FIFO takes the slave side; the producer/consumer takes the master side.
interface srl_fifo_rd32x36_if #(
    parameter int WIDTH = 36,
    parameter int AW    = 5
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_d;
    logic             full;
    logic             ovf;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [AW+1:0]    level;

    modport master (
        output wr_en, wr_d, rd_ready,
        input  full, ovf, rd_data, rd_valid, level
    );

    modport slave (
        input  wr_en, wr_d, rd_ready,
        output full, ovf, rd_data, rd_valid, level
    );
endinterface

// File: rtl/srl_fifo_rd32x36.sv
// FIFO over an addressable shift-register store with a registered valid/ready output stage.
// Newest word sits at store address 0; the oldest is read at cnt-1.
module srl_fifo_rd32x36 #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    srl_fifo_rd32x36_if.slave  fifo
);
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
    localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   ONE_C   = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] store_r [DEPTH];
    logic [AW:0]      cnt_r;
    logic [AW:0]      cnt_nxt_s;
    logic             rd_valid_r;
    logic             rd_valid_nxt_s;
    logic [WIDTH-1:0] rd_data_r;
    logic [WIDTH-1:0] rd_data_nxt_s;
    logic             full_r;
    logic             ovf_r;
    logic [AW+1:0]    level_r;
    logic [AW+1:0]    level_nxt_s;
    logic             push_s;
    logic             load_s;
    logic [AW-1:0]    rd_addr_s;
    logic [WIDTH-1:0] rd_word_s;

    // Full is checked before any pop, so a push into a full store is dropped even if a load frees a slot.
    assign push_s    = fifo.wr_en & ~full_r;
    assign load_s    = (cnt_r != {(AW+1){1'b0}}) & (~rd_valid_r | fifo.rd_ready);
    assign rd_addr_s = cnt_r[AW-1:0] - ONE_A;
    assign rd_word_s = store_r[rd_addr_s];

    // Shift store: new word enters at address 0, older words move up one slot.
    always_ff @(posedge clk) begin
        if (push_s) begin
            store_r[0] <= fifo.wr_d;
            for (int i = 1; i < DEPTH; i++) begin
                store_r[i] <= store_r[i-1];
            end
        end
    end

    // Next occupancy and output-stage state.
    always_comb begin
        cnt_nxt_s      = cnt_r;
        rd_valid_nxt_s = rd_valid_r;
        rd_data_nxt_s  = rd_data_r;
        case ({push_s, load_s})
            2'b10:   cnt_nxt_s = cnt_r + ONE_C;
            2'b01:   cnt_nxt_s = cnt_r - ONE_C;
            default: cnt_nxt_s = cnt_r;
        endcase
        if (load_s) begin
            rd_data_nxt_s  = rd_word_s;
            rd_valid_nxt_s = 1'b1;
        end else if (fifo.rd_ready) begin
            rd_valid_nxt_s = 1'b0;
        end else begin
            rd_valid_nxt_s = rd_valid_r;
        end
        level_nxt_s = {1'b0, cnt_nxt_s} + {{(AW+1){1'b0}}, rd_valid_nxt_s};
    end

    // Control and status registers; store contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r      <= {(AW+1){1'b0}};
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
            full_r     <= 1'b0;
            ovf_r      <= 1'b0;
            level_r    <= {(AW+2){1'b0}};
        end else begin
            cnt_r      <= cnt_nxt_s;
            rd_valid_r <= rd_valid_nxt_s;
            rd_data_r  <= rd_data_nxt_s;
            full_r     <= (cnt_nxt_s == DEPTH_C);
            ovf_r      <= fifo.wr_en & full_r;
            level_r    <= level_nxt_s;
        end
    end

    assign fifo.rd_data  = rd_data_r;
    assign fifo.rd_valid = rd_valid_r;
    assign fifo.full     = full_r;
    assign fifo.ovf      = ovf_r;
    assign fifo.level    = level_r;
endmodule
